can_bit_destuff: RTL and testbench

CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

---
 rtl/can_pkg.sv | 23 ++
 rtl/can_run_cnt.sv | 60 ++++++
 rtl/can_bit_destuff.sv | 147 ++++++++++++++
 tb/tb_can_bit_destuff.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN bit-level definitions: FSM state encoding and default
// stuffing / word-size parameters used by both the destuffer and the stuffer.
package can_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STUFF = 2'd2,
    ST_ERR   = 2'd3
  } can_state_e;

  // Equal consecutive bits after which a stuff bit of opposite polarity follows.
  localparam int STUFF_LEN_DEF = 5;

  // Width of the deserialised word.
  localparam int BYTE_W_DEF = 8;

  // Width of a run counter able to hold values 0..stuff_len.
  function automatic int run_cnt_w(input int stuff_len);
    return $clog2(stuff_len + 1);
  endfunction

endpackage

// File: rtl/can_run_cnt.sv
// Run-length tracker: remembers the last bit and how many equal bits have
// been seen in a row, saturating at STUFF_LEN. The next-state run value is
// exported so the FSM can decide on the same edge that the run is updated.
module can_run_cnt
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr_i,    // forget everything (frame abort)
  input  logic                            start_i,  // bit_i starts a fresh run of length 1
  input  logic                            track_i,  // bit_i extends or restarts the run
  input  logic                            bit_i,
  output logic [run_cnt_w(STUFF_LEN)-1:0] run_next_o,
  output logic                            last_o
);

  localparam int RUN_W = run_cnt_w(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;

  // Next run/last: clear wins, then explicit restart, then normal tracking.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clr_i) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (start_i) begin
      run_d  = RUN_ONE;
      last_d = bit_i;
    end else if (track_i) begin
      if (bit_i == last_q) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
      end else begin
        run_d  = RUN_ONE;
        last_d = bit_i;
      end
    end
  end

  // Run/last registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign run_next_o = run_d;
  assign last_o     = last_q;

endmodule

// File: rtl/can_bit_destuff.sv
// CAN bit destuffer: removes the stuff bit inserted after STUFF_LEN equal
// bits, flags stuff-rule violations, and deserialises the destuffed stream
// MSB-first into BYTE_W-bit words. All outputs are registered (1-cycle latency).
// BYTE_W must be at least 2.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int BYTE_W    = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din,
  input  logic              din_valid,
  output logic              dout,
  output logic              dout_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              stuff_err
);

  localparam int RUN_W = run_cnt_w(STUFF_LEN);
  localparam int CNT_W = $clog2(BYTE_W) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  can_state_e        state_q, state_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              byte_valid_q, byte_valid_d;
  logic              stuff_err_q, stuff_err_d;
  logic [BYTE_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              run_clr, run_start, run_track, fwd;
  logic [RUN_W-1:0]  run_next;
  logic              last_bit;

  can_run_cnt #(
    .STUFF_LEN (STUFF_LEN)
  ) u_run_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (run_clr),
    .start_i    (run_start),
    .track_i    (run_track),
    .bit_i      (din),
    .run_next_o (run_next),
    .last_o     (last_bit)
  );

  // Next-state, forwarding and deserialiser logic; abort (en=0) overrides all.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    run_clr      = 1'b0;
    run_start    = 1'b0;
    run_track    = 1'b0;
    fwd          = 1'b0;

    if (!en) begin
      state_d     = ST_IDLE;
      stuff_err_d = 1'b0;
      word_d      = '0;
      cnt_d       = '0;
      run_clr     = 1'b1;
    end else if (din_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          run_start = 1'b1;
          fwd       = 1'b1;
        end
        ST_RUN: begin
          run_track = 1'b1;
          fwd       = 1'b1;
        end
        ST_STUFF: begin
          if (din != last_bit) begin
            // Stuff bit: dropped, but it opens the next run.
            run_start = 1'b1;
            state_d   = ST_RUN;
          end else begin
            stuff_err_d = 1'b1;
            state_d     = ST_ERR;
          end
        end
        ST_ERR: begin
          // Stay silent until the frame is aborted.
        end
        default: state_d = ST_IDLE;
      endcase

      if (fwd) begin
        dout_d       = din;
        dout_valid_d = 1'b1;
        word_d       = {word_q[BYTE_W-2:0], din};
        if (cnt_q == CNT_LAST) begin
          byte_d       = word_d;
          byte_valid_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        state_d = (run_next == RUN_MAX) ? ST_STUFF : ST_RUN;
      end
    end
  end

  // State and output registers; reset outranks en and din_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      word_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      stuff_err_q  <= stuff_err_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed testbench for can_bit_destuff with hand-computed expectations.
module tb_can_bit_destuff;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       din_valid;
  logic       dout;
  logic       dout_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       stuff_err;

  int n_cmp = 0;
  int n_mis = 0;

  can_bit_destuff dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .stuff_err  (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive n bits (first bit = bits[n-1]); vmask gives which ones must be forwarded.
  // byte_at is the bit index whose edge must also raise byte_valid (-1 for none).
  task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                         input logic [15:0] vmask, input int gap,
                         input int byte_at, input logic [7:0] byte_exp);
    for (int i = 0; i < n; i++) begin
      logic b;
      logic v;
      b = bits[n-1-i];
      v = vmask[n-1-i];
      @(negedge clk);
      din       = b;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      check_eq($sformatf("%s.dv%0d", tag, i), {31'd0, dout_valid}, {31'd0, v});
      if (v) check_eq($sformatf("%s.d%0d", tag, i), {31'd0, dout}, {31'd0, b});
      check_eq($sformatf("%s.bv%0d", tag, i), {31'd0, byte_valid}, {31'd0, (i == byte_at)});
      if (i == byte_at) check_eq($sformatf("%s.byte", tag), {24'd0, byte_out}, {24'd0, byte_exp});
      $display("%s bit%0d din=%0b dout_valid=%0b dout=%0b byte_valid=%0b byte_out=%02h stuff_err=%0b",
               tag, i, b, dout_valid, dout, byte_valid, byte_out, stuff_err);
      din_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        check_eq($sformatf("%s.gap%0d_%0d", tag, i, g), {30'd0, dout_valid, byte_valid}, 32'd0);
      end
    end
  endtask

  // One en=0 cycle to start a clean frame.
  task automatic frame_reset(input string tag);
    @(negedge clk);
    en        = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, ".abort_err"}, {31'd0, stuff_err}, 32'd0);
    check_eq({tag, ".abort_dv"}, {31'd0, dout_valid}, 32'd0);
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.dout", {31'd0, dout}, 32'd0);
    check_eq("rst.dv", {31'd0, dout_valid}, 32'd0);
    check_eq("rst.byte", {24'd0, byte_out}, 32'd0);
    check_eq("rst.bv", {31'd0, byte_valid}, 32'd0);
    check_eq("rst.err", {31'd0, stuff_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Alternating bits, no stuffing: AA.
    run_seq("alt", 8, 16'h00AA, 16'h00FF, 0, 7, 8'hAA);

    // Five zeros then a stuff bit (1) that must disappear: forwarded 00000101.
    frame_reset("stf");
    run_seq("stf", 9, 16'b0000000_000001101, 16'b0000000_111110111, 0, 8, 8'h05);
    check_eq("stf.err", {31'd0, stuff_err}, 32'd0);

    // Six equal bits: violation, then silence until abort.
    frame_reset("viol");
    run_seq("viol", 8, 16'b00000000_11111101, 16'b00000000_11111000, 0, -1, 8'h00);
    check_eq("viol.err", {31'd0, stuff_err}, 32'd1);
    frame_reset("viol_clr");

    // Abort after three bits (with an ignored valid bit), then 5A from scratch.
    run_seq("part", 3, 16'b110, 16'b111, 0, -1, 8'h00);
    @(negedge clk);
    en        = 1'b0;
    din       = 1'b1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort.dv", {31'd0, dout_valid}, 32'd0);
    @(negedge clk);
    en        = 1'b1;
    din_valid = 1'b0;
    run_seq("5a", 8, 16'h005A, 16'h00FF, 0, 7, 8'h5A);
    check_eq("5a.err", {31'd0, stuff_err}, 32'd0);

    // Stuff sequence again with three idle cycles between bits.
    frame_reset("gap");
    run_seq("gap", 9, 16'b0000000_000001101, 16'b0000000_111110111, 3, 8, 8'h05);

    // Reset while in STUFF, with a valid bit present: reset wins.
    frame_reset("rs");
    run_seq("rs_pre", 5, 16'b11111, 16'b11111, 0, -1, 8'h00);
    @(negedge clk);
    rst_n     = 1'b0;
    din       = 1'b1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rs.dout", {31'd0, dout}, 32'd0);
    check_eq("rs.dv", {31'd0, dout_valid}, 32'd0);
    check_eq("rs.byte", {24'd0, byte_out}, 32'd0);
    check_eq("rs.bv", {31'd0, byte_valid}, 32'd0);
    check_eq("rs.err", {31'd0, stuff_err}, 32'd0);
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("rs_post", 6, 16'b111110, 16'b111110, 0, -1, 8'h00);
    check_eq("rs_post.err", {31'd0, stuff_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
